sinusoid_increment: RTL and testbench
=====================================

Name: sinusoid_increment

Overview:
- Converts a requested oscillator frequency in Hz into the 32-bit phase-accumulator increment for the sinusoid NCO of the AC97 synth voice.
- Computes Sin_inc = floor(Freq * 2^32 / SAMPLE_RATE) using a multi-cycle restoring divider.
- Recomputes automatically whenever Freq changes.
- Sits between the note/frequency control logic and the phase accumulator / sine lookup.

Parameters:
- SAMPLE_RATE, 48000: audio sample rate in Hz (divisor). Must be nonzero and < 2^31.
- WIDTH, 32: width of Freq, Sin_inc and the phase accumulator.

Ports:
- Sys_clk  in  1  system clock; all state updates on rising edge.
- Sin_rst  in  1  asynchronous active-high reset.
- Sin_ce  in  1  clock enable; when 0 all internal state and the output are frozen.
- Freq  in  32  requested frequency, unsigned integer Hz.
- Sin_inc  out  32  registered phase increment per sample.

Behaviour:
- Reset (async, Sin_rst=1):
  - Sin_inc=0, state=IDLE, latched frequency F_q=0, valid=0.
  - Reset mid-division aborts the division immediately.
- States:
  - IDLE: if Sin_ce=1 and (valid=0 or Freq!=F_q), latch F_q<=Freq and go to CHECK. Otherwise stay in IDLE.
  - CHECK:
    - F_q>=SAMPLE_RATE: Sin_inc<=32'hFFFF_FFFF (saturate), valid<=1, go to IDLE.
    - F_q=0: Sin_inc<=0, valid<=1, go to IDLE.
    - Otherwise: rem<=F_q (33-bit), quot<=0, count<=0, go to DIV.
  - DIV: one quotient bit per enabled cycle, MSB first, 32 iterations.
    - t=rem<<1; if t>=SAMPLE_RATE then rem<=t-SAMPLE_RATE and qbit=1, else rem<=t and qbit=0.
    - quot<={quot[30:0],qbit}.
    - After the 32nd iteration go to DONE.
  - DONE: Sin_inc<=quot, valid<=1, go to IDLE.
- Latency: Sin_inc reflects a new Freq 35 enabled clock edges after the Freq change is present at a rising edge (IDLE detect + CHECK + 32 DIV + DONE). Saturate/zero cases take 2 edges.
- Sin_inc holds its previous value during computation and never shows partial quotients.
- Freq changes during CHECK/DIV are ignored. On return to IDLE the mismatch with F_q triggers a fresh computation, so the final output always matches the last stable Freq.
- Sin_ce=0: no state advances and Sin_inc holds; computation resumes where it paused when Sin_ce returns to 1.
- Result is truncated (floor), never rounded. All arithmetic is unsigned.

Decomposition:
- Shared package: SAMPLE_RATE default, WIDTH, and the state enum (IDLE, CHECK, DIV, DONE).
- One natural sub-module: seq_divider. It is a generic restoring divider with start/busy/done, dividend {F_q, 32'b0} and a constant divisor.
- The top handles change detection, saturation and output registering.

Test Plan:
- Reset: assert Sin_rst asynchronously mid-cycle -> Sin_inc=0 immediately. Release with Sin_ce=0 -> Sin_inc stays 0 indefinitely.
- Sin_ce=1, Freq=440 -> after 35 cycles Sin_inc=39370533 (0x0258BF25), stable thereafter. Then Freq=880 -> Sin_inc=78741067 after 35 cycles. Then Freq=1000 -> 89478485.
- Freq=0 -> Sin_inc=0 after 2 cycles. Freq=48000 or 0xFFFFFFFF -> Sin_inc=0xFFFFFFFF after 2 cycles. Freq=24000 -> 0x80000000 after 35 cycles.
- Change Freq 440->880 at cycle 10 of an ongoing division -> Sin_inc first shows 39370533, then 78741067 about 35 cycles later; no intermediate garbage.
- Drop Sin_ce for 20 cycles mid-division with Freq=1000 -> Sin_inc holds its old value; final 89478485 appears 55 cycles after start.
- Random Freq in [1, 47999] with a long wait each -> Sin_inc equals the reference model floor(Freq*2^32/48000).

Source files
------------

// File: rtl/sinusoid_increment_pkg.sv
// Shared widths, default sample rate and FSM state codes for the sinusoid
// phase-increment calculator.
package sinusoid_increment_pkg;

    localparam int unsigned WIDTH           = 32;
    localparam int unsigned SAMPLE_RATE_DEF = 48000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sinusoid_increment_seq_divider.sv
// Restoring divider by a constant: one quotient bit per enabled cycle, MSB first.
// The upper dividend half must be below the divisor so the quotient fits W bits.
module sinusoid_increment_seq_divider #(
    parameter int unsigned W       = 32,
    parameter int unsigned DIVISOR = 48000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           ce_i,
    input  logic           start_i,
    input  logic [2*W-1:0] dividend_i,
    output logic           busy_o,
    output logic           done_c_o,
    output logic [W-1:0]   quot_o
);

    localparam int unsigned CW = $clog2(W);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic [W:0]    trial;
    logic          qbit;

    // Low dividend bits shift out of shreg into rem while quotient bits shift in.
    always_comb begin
        rem_d   = rem_q;
        shreg_d = shreg_q;
        count_d = count_q;
        busy_d  = busy_q;
        trial   = {rem_q, shreg_q[W-1]};
        qbit    = (trial >= (W+1)'(DIVISOR));
        if (start_i) begin
            rem_d   = dividend_i[2*W-1:W];
            shreg_d = dividend_i[W-1:0];
            count_d = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            rem_d   = qbit ? W'(trial - (W+1)'(DIVISOR)) : W'(trial);
            shreg_d = {shreg_q[W-2:0], qbit};
            count_d = count_q + CW'(1);
            if (count_q == CW'(W-1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q   <= '0;
            shreg_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (ce_i) begin
            rem_q   <= rem_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_c_o = ce_i && busy_q && (count_q == CW'(W-1));
    assign quot_o   = shreg_q;

endmodule

// File: rtl/sinusoid_increment.sv
// Converts a frequency in Hz into the NCO phase increment floor(Freq*2^32/SAMPLE_RATE),
// recomputing whenever Freq differs from the last latched value.
module sinusoid_increment
    import sinusoid_increment_pkg::*;
#(
    parameter int unsigned SAMPLE_RATE = SAMPLE_RATE_DEF
) (
    input  logic             Sys_clk,
    input  logic             Sin_rst,
    input  logic             Sin_ce,
    input  logic [WIDTH-1:0] Freq,
    output logic [WIDTH-1:0] Sin_inc
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [WIDTH-1:0] inc_q, inc_d;
    logic             valid_q, valid_d;
    logic             div_start;
    logic             div_busy;
    logic             div_done_c;
    logic [WIDTH-1:0] div_quot;

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        inc_d     = inc_q;
        valid_d   = valid_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Sin_ce && (!valid_q || (Freq != f_q))) begin
                    f_d     = Freq;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (f_q >= WIDTH'(SAMPLE_RATE)) begin
                    inc_d   = '1;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (f_q == '0) begin
                    inc_d   = '0;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    div_start = Sin_ce;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done_c) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                inc_d   = div_quot;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Sys_clk or posedge Sin_rst) begin
        if (Sin_rst) begin
            state_q <= ST_IDLE;
            f_q     <= '0;
            inc_q   <= '0;
            valid_q <= 1'b0;
        end else if (Sin_ce) begin
            state_q <= state_d;
            f_q     <= f_d;
            inc_q   <= inc_d;
            valid_q <= valid_d;
        end
    end

    sinusoid_increment_seq_divider #(
        .W       (WIDTH),
        .DIVISOR (SAMPLE_RATE)
    ) u_div (
        .clk_i      (Sys_clk),
        .rst_i      (Sin_rst),
        .ce_i       (Sin_ce),
        .start_i    (div_start),
        .dividend_i ({f_q, WIDTH'(0)}),
        .busy_o     (div_busy),
        .done_c_o   (div_done_c),
        .quot_o     (div_quot)
    );

    assign Sin_inc = inc_q;

endmodule

// File: tb/tb_sinusoid_increment.sv
// Self-checking bench for sinusoid_increment: directed vector table, multi-cycle
// corner sequences and random frequencies against an arithmetic reference.
module tb_sinusoid_increment;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] freq;
    logic [31:0] inc;

    int checks = 0;
    int errors = 0;

    sinusoid_increment dut (
        .Sys_clk (clk),
        .Sin_rst (rst),
        .Sin_ce  (ce),
        .Freq    (freq),
        .Sin_inc (inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] model(input logic [31:0] f);
        longint unsigned q;
        if (f == 32'd0) return 32'd0;
        if (f >= 32'd48000) return 32'hFFFF_FFFF;
        q = (64'(f) << 32) / 64'd48000;
        return 32'(q);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] prev;
    logic [31:0] rf;
    logic [31:0] e;

    initial begin
        vecs[0] = '{32'd440,        35, 32'd39370533};
        vecs[1] = '{32'd880,        35, 32'd78741067};
        vecs[2] = '{32'd1000,       35, 32'd89478485};
        vecs[3] = '{32'd0,           2, 32'd0};
        vecs[4] = '{32'd48000,       2, 32'hFFFF_FFFF};
        vecs[5] = '{32'd1,          35, 32'd89478};
        vecs[6] = '{32'hFFFF_FFFF,   2, 32'hFFFF_FFFF};
        vecs[7] = '{32'd24000,      35, 32'h8000_0000};

        rst  = 1'b1;
        ce   = 1'b0;
        freq = 32'd0;
        cycles(2);
        check("reset_value", inc, 32'd0);
        rst = 1'b0;
        cycles(2);

        // Directed table: output must hold old value until exactly the latency edge.
        prev = 32'd0;
        ce   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            freq = vecs[i].f;
            cycles(vecs[i].lat - 1);
            check($sformatf("vec%0d_hold", i), inc, prev);
            cycles(1);
            check($sformatf("vec%0d_result", i), inc, vecs[i].exp);
            cycles(10);
            check($sformatf("vec%0d_stable", i), inc, vecs[i].exp);
            prev = vecs[i].exp;
        end

        // Asynchronous reset mid-cycle clears the output before any clock edge.
        #2 rst = 1'b1;
        #1 check("async_reset", inc, 32'd0);
        @(negedge clk);
        ce   = 1'b0;
        freq = 32'd440;
        rst  = 1'b0;
        cycles(50);
        check("reset_ce_low_hold", inc, 32'd0);

        // Freq change during division: 440 result first, then 880, nothing else.
        ce = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 10) freq = 32'd880;
            e = (k < 35) ? 32'd0 : (k < 70) ? 32'd39370533 : 32'd78741067;
            check($sformatf("midchange_k%0d", k), inc, e);
        end

        // Clock-enable pause of 20 cycles mid-division stretches latency to 55.
        freq = 32'd1000;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 10) ce = 1'b0;
            if (k == 30) ce = 1'b1;
            e = (k < 55) ? 32'd78741067 : 32'd89478485;
            check($sformatf("ce_pause_k%0d", k), inc, e);
        end

        // Random frequencies against the arithmetic reference.
        for (int i = 0; i < 25; i++) begin
            rf   = 32'($urandom_range(47999, 1));
            freq = rf;
            cycles(40);
            check($sformatf("random_%0d_f%0d", i, rf), inc, model(rf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
